// File: rtl/store_drain_queue_if.sv
// store_drain_queue_if: D$ write request bus between the store queue and the D$.
//   master (store queue): drives req/addr/data/be/size, samples gnt
//   slave  (D$)         : samples req/addr/data/be/size, drives gnt
interface store_drain_queue_if #(
  parameter int PLEN = 56,
  parameter int XLEN = 64
);
  logic              req;
  logic [PLEN-1:0]   addr;
  logic [XLEN-1:0]   data;
  logic [XLEN/8-1:0] be;
  logic [1:0]        size;
  logic              gnt;
  modport master (output req, addr, data, be, size, input gnt);
  modport slave (input req, addr, data, be, size, output gnt);
endinterface

// File: rtl/store_drain_queue.sv
// store_drain_queue: speculative store FIFO feeding a commit FIFO drained in order to the D$.
//   clk_i/rst_i            clock, async active-high reset
//   flush_i                drop all speculative entries
//   stall_st_pending_i     hold off new D$ requests
//   valid_i/ready_o        store push (paddr_i, data_i, be_i, data_size_i)
//   valid_without_flush_i  ungated valid, used only by the alias check
//   commit_i/commit_ready_o move spec head into the commit FIFO
//   page_offset_i/page_offset_matches_o  load alias check on paddr[11:3]
//   no_st_pending_o, store_buffer_empty_o  drain status
//   dc                     D$ write request bus (master side)
//   perf_stall_cnt_o       D$ back-pressure cycles, built only with STORE_DRAIN_PERF_EN
module store_drain_queue #(
  parameter int PLEN         = 56,
  parameter int XLEN         = 64,
  parameter int SPEC_DEPTH   = 4,
  parameter int COMMIT_DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                stall_st_pending_i,
  input  logic                valid_i,
  input  logic                valid_without_flush_i,
  output logic                ready_o,
  input  logic [PLEN-1:0]     paddr_i,
  input  logic [XLEN-1:0]     data_i,
  input  logic [XLEN/8-1:0]   be_i,
  input  logic [1:0]          data_size_i,
  input  logic                commit_i,
  output logic                commit_ready_o,
  input  logic [11:0]         page_offset_i,
  output logic                page_offset_matches_o,
  output logic                no_st_pending_o,
  output logic                store_buffer_empty_o,
  store_drain_queue_if.master dc,
  output logic [31:0]         perf_stall_cnt_o
);
  localparam int SW = $clog2(SPEC_DEPTH);
  localparam int CW = $clog2(COMMIT_DEPTH);
  typedef struct packed {
    logic [PLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
    logic [1:0]        size;
  } entry_t;
  typedef enum logic {IDLE, REQ} state_e;
  entry_t        spec_mem_q [SPEC_DEPTH];
  entry_t        com_mem_q [COMMIT_DEPTH];
  logic [SW-1:0] spec_rd_q, spec_rd_d, spec_wr_q, spec_wr_d;
  logic [SW:0]   spec_cnt_q, spec_cnt_d;
  logic [CW-1:0] com_rd_q, com_rd_d, com_wr_q, com_wr_d;
  logic [CW:0]   com_cnt_q, com_cnt_d;
  state_e        state_q, state_d;
  logic          push, pop;
  entry_t        head;
  assign ready_o              = spec_cnt_q != (SW+1)'(SPEC_DEPTH);
  assign commit_ready_o       = com_cnt_q != (CW+1)'(COMMIT_DEPTH);
  assign push                 = valid_i & ready_o & ~flush_i;
  assign pop                  = dc.gnt & (state_q == REQ);
  assign head                 = com_mem_q[com_rd_q];
  assign dc.req               = state_q == REQ;
  assign dc.addr              = head.addr;
  assign dc.data              = head.data;
  assign dc.be                = head.be;
  assign dc.size              = head.size;
  assign no_st_pending_o      = com_cnt_q == '0 && state_q == IDLE;
  assign store_buffer_empty_o = no_st_pending_o && spec_cnt_q == '0;
  always_comb begin
    spec_rd_d  = flush_i ? '0 : spec_rd_q + SW'(commit_i);
    spec_wr_d  = flush_i ? '0 : spec_wr_q + SW'(push);
    spec_cnt_d = flush_i ? '0 : spec_cnt_q + (SW+1)'(push) - (SW+1)'(commit_i);
    com_rd_d   = com_rd_q + CW'(pop);
    com_wr_d   = com_wr_q + CW'(commit_i);
    com_cnt_d  = com_cnt_q + (CW+1)'(commit_i) - (CW+1)'(pop);
  end
  // Looking at the next commit count lets a commit into an empty FIFO raise
  // dc_req_o one cycle later; an ungranted request is never withdrawn.
  always_comb begin
    state_d = ((state_q == REQ && !dc.gnt) || (com_cnt_d != '0 && !stall_st_pending_i)) ? REQ : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_rd_q  <= '0;
      spec_wr_q  <= '0;
      spec_cnt_q <= '0;
      com_rd_q   <= '0;
      com_wr_q   <= '0;
      com_cnt_q  <= '0;
      state_q    <= IDLE;
    end else begin
      spec_rd_q  <= spec_rd_d;
      spec_wr_q  <= spec_wr_d;
      spec_cnt_q <= spec_cnt_d;
      com_rd_q   <= com_rd_d;
      com_wr_q   <= com_wr_d;
      com_cnt_q  <= com_cnt_d;
      state_q    <= state_d;
    end
  end
  // Storage needs no reset: validity comes from the pointers and counts.
  always_ff @(posedge clk_i) begin
    if (push) spec_mem_q[spec_wr_q] <= {paddr_i, data_i, be_i, data_size_i};
    if (commit_i) com_mem_q[com_wr_q] <= spec_mem_q[spec_rd_q];
  end
  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    page_offset_matches_o = valid_without_flush_i && paddr_i[11:3] == page_offset_i[11:3];
    for (int i = 0; i < SPEC_DEPTH; i++)
      if ({1'b0, SW'(i) - spec_rd_q} < spec_cnt_q && spec_mem_q[i].addr[11:3] == page_offset_i[11:3])
        page_offset_matches_o = 1'b1;
    for (int i = 0; i < COMMIT_DEPTH; i++)
      if ({1'b0, CW'(i) - com_rd_q} < com_cnt_q && com_mem_q[i].addr[11:3] == page_offset_i[11:3])
        page_offset_matches_o = 1'b1;
  end
`ifdef STORE_DRAIN_PERF_EN
  logic [31:0] perf_q, perf_d;
  assign perf_d = perf_q + 32'(dc.req & ~dc.gnt & (perf_q != '1));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = '0;
`endif
  a_commit_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_i |-> (spec_cnt_q != '0 && commit_ready_o));
endmodule

// File: tb/tb_store_drain_queue.sv
// tb_store_drain_queue: directed and random stimulus against a queue-based reference model.
module tb_store_drain_queue;
  localparam int PLEN = 56, XLEN = 64, SD = 4, CD = 8;
`ifdef STORE_DRAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic [PLEN-1:0] a;
    logic [XLEN-1:0] d;
    logic [7:0]      be;
    logic [1:0]      sz;
  } ent_t;
  logic clk = 1'b0;
  logic rst, flush, stall, valid, vwf, commit, gnt;
  logic [PLEN-1:0] paddr;
  logic [XLEN-1:0] data;
  logic [7:0] be;
  logic [1:0] dsize;
  logic [11:0] poff;
  logic ready, cready, match, nsp, sbe;
  logic [31:0] perf_o;
  int total = 0, bad = 0;
  ent_t sq[$], cq[$];
  bit open;
  logic [31:0] mperf;
  store_drain_queue_if #(.PLEN(PLEN), .XLEN(XLEN)) dc ();
  assign dc.gnt = gnt;
  store_drain_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_st_pending_i(stall),
    .valid_i(valid), .valid_without_flush_i(vwf), .ready_o(ready),
    .paddr_i(paddr), .data_i(data), .be_i(be), .data_size_i(dsize),
    .commit_i(commit), .commit_ready_o(cready),
    .page_offset_i(poff), .page_offset_matches_o(match),
    .no_st_pending_o(nsp), .store_buffer_empty_o(sbe),
    .dc(dc), .perf_stall_cnt_o(perf_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit model_match();
    bit m;
    m = vwf && paddr[11:3] == poff[11:3];
    foreach (sq[i]) m = m | (sq[i].a[11:3] == poff[11:3]);
    foreach (cq[i]) m = m | (cq[i].a[11:3] == poff[11:3]);
    return m;
  endfunction
  task automatic idle();
    valid = 0; vwf = 0; commit = 0; flush = 0; stall = 0; gnt = 0;
  endtask
  task automatic set_store(input logic [PLEN-1:0] a);
    valid = 1; vwf = 1; paddr = a;
    data = {$urandom(), $urandom()}; be = 8'($urandom()); dsize = 2'($urandom());
  endtask
  task automatic model_clear();
    sq.delete(); cq.delete(); open = 0; mperf = '0;
  endtask
  // Check outputs mid-cycle, then advance the model by the edge that follows.
  task automatic tick();
    bit acc;
    @(negedge clk);
    chk("ready", ready, sq.size() < SD);
    chk("commit_ready", cready, cq.size() < CD);
    chk("no_st_pending", nsp, cq.size() == 0 && !open);
    chk("sb_empty", sbe, cq.size() == 0 && !open && sq.size() == 0);
    chk("dc_req", dc.req, open);
    if (open) begin
      chk("dc_addr", dc.addr, cq[0].a);
      chk("dc_data", dc.data, cq[0].d);
      chk("dc_be", dc.be, cq[0].be);
      chk("dc_size", dc.size, cq[0].sz);
    end
    chk("match", match, model_match());
    chk("perf", perf_o, PERF ? mperf : 32'd0);
    acc = valid && !flush && sq.size() < SD;
    if (open && gnt) void'(cq.pop_front());
    if (commit) cq.push_back(sq.pop_front());
    if (acc) sq.push_back('{paddr, data, be, dsize});
    if (flush) sq.delete();
    if (open && !gnt && mperf != 32'hFFFF_FFFF) mperf++;
    open = (open && !gnt) || (cq.size() > 0 && !stall);
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    paddr = '0; data = '0; be = '0; dsize = '0; poff = 12'h000;
    rst = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_commit_ready", cready, 1);
    chk("rst_nsp", nsp, 1);
    chk("rst_sbe", sbe, 1);
    chk("rst_req", dc.req, 0);
    chk("rst_perf", perf_o, 0);
    rst = 0;
    // Fill the spec FIFO; the fifth store must be ignored.
    for (int i = 0; i < 5; i++) begin
      set_store(PLEN'(32'h100 + 8 * i));
      tick();
    end
    idle();
    chk("full_ready", ready, 0);
    chk("full_sbe", sbe, 0);
    chk("full_nsp", nsp, 1);
    flush = 1;
    tick();
    idle();
    // Single store, commit, three cycles of D$ back-pressure.
    set_store(PLEN'(32'h1008));
    tick();
    idle();
    commit = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", dc.req, 1);
      chk("bp_addr", dc.addr, 64'h1008);
      tick();
    end
    gnt = 1;
    tick();
    idle();
    chk("bp_perf", perf_o, PERF ? 32'd3 : 32'd0);
    chk("bp_req_off", dc.req, 0);
    // Three stores, one committed, then flush while the committed one drains.
    for (int i = 0; i < 3; i++) begin
      set_store(PLEN'(32'h2000 + 8 * i));
      tick();
    end
    idle();
    commit = 1;
    tick();
    idle();
    flush = 1; gnt = 1;
    tick();
    idle();
    tick();
    chk("flush_sbe", sbe, 1);
    // Eight committed stores held by stall, then drained back-to-back.
    stall = 1;
    for (int i = 0; i < 9; i++) begin
      valid = 0; vwf = 0; commit = i >= 1;
      if (i < 8) set_store(PLEN'(32'h3000 + 8 * i));
      tick();
    end
    idle();
    stall = 1;
    tick();
    chk("stall_req", dc.req, 0);
    chk("stall_cready", cready, 0);
    idle();
    gnt = 1;
    for (int i = 0; i < 9; i++) tick();
    idle();
    chk("drain_nsp", nsp, 1);
    chk("drain_sbe", sbe, 1);
    // Alias check against a live spec entry.
    set_store(PLEN'(32'h2A38));
    tick();
    idle();
    poff = 12'hA3C;
    #1;
    chk("alias_hit", match, 1);
    poff = 12'hA40;
    #1;
    chk("alias_miss", match, 0);
    tick();
    // Reset while a request is open.
    commit = 1;
    tick();
    idle();
    tick();
    chk("pre_rst_req", dc.req, 1);
    rst = 1;
    #1;
    chk("async_rst_req", dc.req, 0);
    chk("async_rst_sbe", sbe, 1);
    model_clear();
    @(posedge clk);
    #1;
    rst = 0;
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      valid = 1'($urandom_range(0, 1));
      vwf = valid | ($urandom_range(0, 7) == 0);
      paddr = PLEN'({$urandom(), $urandom()});
      paddr[11:0] = 12'hA00 | 12'($urandom_range(0, 63));
      data = {$urandom(), $urandom()};
      be = 8'($urandom());
      dsize = 2'($urandom());
      poff = 12'hA00 | 12'($urandom_range(0, 63));
      flush = $urandom_range(0, 19) == 0;
      stall = $urandom_range(0, 3) == 0;
      commit = sq.size() > 0 && cq.size() < CD && $urandom_range(0, 1) == 1;
      gnt = $urandom_range(0, 2) != 0;
      tick();
    end
    idle();
    flush = 1; gnt = 1;
    tick();
    idle();
    gnt = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("end_sbe", sbe, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
